// File: rtl/rom_region_loader.sv
// rom_region_loader: turns a region-tagged ioctl ROM image into SDRAM word
// writes and BRAM byte writes, and captures the board configuration word.
//
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   ioctl_download/wr/dout, ioctl_wait : MiSTer download byte stream
//   sdr_req/ack/addr/data              : SDRAM word write, level req / pulse ack
//   bram_wr/cs/addr/data               : one-cycle BRAM byte write
//   board_cfg                          : config word from the image
//   load_done, load_error              : image status, sticky per download

package rom_region_pkg;

    typedef struct packed {
        logic [24:0] base;
        logic        reorder_64;
        logic [4:0]  bram_cs;
    } region_t;

    typedef region_t [7:0] region_tbl_t;

    localparam region_t R_PROG  = '{base: 25'h0000000, reorder_64: 1'b0, bram_cs: 5'b00000};
    localparam region_t R_CHAR  = '{base: 25'h0200000, reorder_64: 1'b0, bram_cs: 5'b00000};
    localparam region_t R_SPR   = '{base: 25'h0400000, reorder_64: 1'b1, bram_cs: 5'b00000};
    localparam region_t R_TILE  = '{base: 25'h0800000, reorder_64: 1'b1, bram_cs: 5'b00000};
    localparam region_t R_CRYPT = '{base: 25'h0000000, reorder_64: 1'b0, bram_cs: 5'b00001};
    localparam region_t R_SND   = '{base: 25'h0000000, reorder_64: 1'b0, bram_cs: 5'b00010};
    localparam region_t R_PROM  = '{base: 25'h0000000, reorder_64: 1'b0, bram_cs: 5'b00100};
    localparam region_t R_MCU   = '{base: 25'h0000000, reorder_64: 1'b0, bram_cs: 5'b01000};

    localparam region_tbl_t LOAD_REGIONS = {
        R_MCU, R_PROM, R_SND, R_CRYPT, R_TILE, R_SPR, R_CHAR, R_PROG
    };

    typedef enum logic [3:0] {
        S_IDLE,
        S_SZ0,
        S_SZ1,
        S_SZ2,
        S_SZ3,
        S_DATA,
        S_CFG0,
        S_CFG1,
        S_DONE,
        S_ERR
    } state_e;

endpackage

module rom_region_loader
    import rom_region_pkg::*;
#(
    parameter region_tbl_t REGIONS    = LOAD_REGIONS,
    parameter int          SDR_ADDR_W = 25
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [7:0]            ioctl_dout,
    output logic                  ioctl_wait,
    output logic                  sdr_req,
    input  logic                  sdr_ack,
    output logic [SDR_ADDR_W-1:0] sdr_addr,
    output logic [15:0]           sdr_data,
    output logic                  bram_wr,
    output logic [4:0]            bram_cs,
    output logic [24:0]           bram_addr,
    output logic [7:0]            bram_data,
    output logic [8:0]            board_cfg,
    output logic                  load_done,
    output logic                  load_error
);

    state_e                state_q, state_d;
    logic                  dl_q, dl_d;
    logic [2:0]            region_q, region_d;
    logic [31:0]           size_q, size_d;
    logic [31:0]           off_q, off_d;
    logic [7:0]            lo_q, lo_d;
    logic                  cfg_hi_q, cfg_hi_d;
    logic                  sdr_req_q, sdr_req_d;
    logic [SDR_ADDR_W-1:0] sdr_addr_q, sdr_addr_d;
    logic [15:0]           sdr_data_q, sdr_data_d;
    logic                  bram_wr_q, bram_wr_d;
    logic [4:0]            bram_cs_q, bram_cs_d;
    logic [24:0]           bram_addr_q, bram_addr_d;
    logic [7:0]            bram_data_q, bram_data_d;
    logic [8:0]            board_cfg_q, board_cfg_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;

    region_t     cur;
    logic        live;
    logic        dl_rise;
    logic        dl_fall;
    logic        byte_v;
    logic        viol;
    logic        ack_v;
    logic        is_bram;
    logic        last_byte;
    logic        all_taken;
    logic        tag_region;
    logic        tag_cfg;
    logic        tag_end;
    logic [31:0] size_nx;
    logic [23:0] w;
    logic [23:0] eff_w;
    logic [24:0] word_addr;

    assign cur       = REGIONS[region_q];
    assign is_bram   = cur.bram_cs != 5'd0;
    assign live      = (state_q != S_DONE) && (state_q != S_ERR);
    assign dl_rise   = ioctl_download & ~dl_q;
    assign dl_fall   = ~ioctl_download & dl_q;

    // A byte offered while the SDRAM request is pending is a violation,
    // never a payload byte.
    assign byte_v    = ioctl_wr & ioctl_download & ~sdr_req_q;
    assign viol      = ioctl_wr & ioctl_download & sdr_req_q & live;
    assign ack_v     = sdr_req_q & sdr_ack;

    assign size_nx   = {size_q[23:0], ioctl_dout};
    assign last_byte = (off_q + 32'd1) == size_q;
    assign all_taken = off_q == size_q;

    assign tag_region = ioctl_dout[7:3] == 5'd0;
    assign tag_cfg    = ioctl_dout == 8'hFE;
    assign tag_end    = ioctl_dout == 8'hFF;

    // Both bytes of a pair share one word index; reorder swaps w[1:0]
    // so each 64-bit group is stored as words 0,2,1,3.
    assign w         = off_q[24:1];
    assign eff_w     = cur.reorder_64 ? {w[23:2], w[0], w[1]} : w;
    assign word_addr = cur.base + {eff_w, 1'b0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            dl_q         <= 1'b0;
            region_q     <= 3'd0;
            size_q       <= 32'd0;
            off_q        <= 32'd0;
            lo_q         <= 8'd0;
            cfg_hi_q     <= 1'b0;
            sdr_req_q    <= 1'b0;
            sdr_addr_q   <= '0;
            sdr_data_q   <= 16'd0;
            bram_wr_q    <= 1'b0;
            bram_cs_q    <= 5'd0;
            bram_addr_q  <= 25'd0;
            bram_data_q  <= 8'd0;
            board_cfg_q  <= 9'd0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dl_q         <= dl_d;
            region_q     <= region_d;
            size_q       <= size_d;
            off_q        <= off_d;
            lo_q         <= lo_d;
            cfg_hi_q     <= cfg_hi_d;
            sdr_req_q    <= sdr_req_d;
            sdr_addr_q   <= sdr_addr_d;
            sdr_data_q   <= sdr_data_d;
            bram_wr_q    <= bram_wr_d;
            bram_cs_q    <= bram_cs_d;
            bram_addr_q  <= bram_addr_d;
            bram_data_q  <= bram_data_d;
            board_cfg_q  <= board_cfg_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (dl_rise) begin
            state_d = S_IDLE;
        end else if (dl_fall && state_q != S_DONE) begin
            state_d = S_ERR;
        end else if (viol) begin
            state_d = S_ERR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (byte_v) begin
                        unique case (1'b1)
                            tag_region: state_d = S_SZ0;
                            tag_cfg:    state_d = S_CFG0;
                            tag_end:    state_d = S_DONE;
                            default:    state_d = S_ERR;
                        endcase
                    end
                end
                S_SZ0: if (byte_v) state_d = S_SZ1;
                S_SZ1: if (byte_v) state_d = S_SZ2;
                S_SZ2: if (byte_v) state_d = S_SZ3;
                S_SZ3: begin
                    if (byte_v) begin
                        state_d = (size_nx == 32'd0) ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (is_bram) begin
                        if (byte_v && last_byte) state_d = S_IDLE;
                    end else begin
                        // SDRAM regions finish only once the last word is taken.
                        if (ack_v && all_taken) state_d = S_IDLE;
                    end
                end
                S_CFG0: if (byte_v) state_d = S_CFG1;
                S_CFG1: if (byte_v) state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        dl_d         = ioctl_download;
        region_d     = region_q;
        size_d       = size_q;
        off_d        = off_q;
        lo_d         = lo_q;
        cfg_hi_d     = cfg_hi_q;
        sdr_req_d    = sdr_req_q;
        sdr_addr_d   = sdr_addr_q;
        sdr_data_d   = sdr_data_q;
        bram_wr_d    = 1'b0;
        bram_cs_d    = bram_cs_q;
        bram_addr_d  = bram_addr_q;
        bram_data_d  = bram_data_q;
        board_cfg_d  = board_cfg_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;

        if (dl_rise) begin
            load_done_d  = 1'b0;
            load_error_d = 1'b0;
            sdr_req_d    = 1'b0;
        end else if ((dl_fall && state_q != S_DONE) || viol) begin
            load_error_d = 1'b1;
            sdr_req_d    = 1'b0;
        end else begin
            if (ack_v) begin
                sdr_req_d = 1'b0;
            end
            if (byte_v) begin
                case (state_q)
                    S_IDLE: begin
                        unique case (1'b1)
                            tag_region: region_d     = ioctl_dout[2:0];
                            tag_cfg:    region_d     = region_q;
                            tag_end:    load_done_d  = 1'b1;
                            default:    load_error_d = 1'b1;
                        endcase
                    end
                    S_SZ0, S_SZ1, S_SZ2: begin
                        size_d = size_nx;
                    end
                    S_SZ3: begin
                        size_d = size_nx;
                        off_d  = 32'd0;
                    end
                    S_DATA: begin
                        off_d = off_q + 32'd1;
                        if (is_bram) begin
                            bram_wr_d   = 1'b1;
                            bram_cs_d   = cur.bram_cs;
                            bram_addr_d = off_q[24:0];
                            bram_data_d = ioctl_dout;
                        end else if (!off_q[0]) begin
                            lo_d = ioctl_dout;
                            // An odd-sized region flushes its last byte alone.
                            if (last_byte) begin
                                sdr_req_d  = 1'b1;
                                sdr_addr_d = SDR_ADDR_W'(word_addr);
                                sdr_data_d = {8'h00, ioctl_dout};
                            end
                        end else begin
                            sdr_req_d  = 1'b1;
                            sdr_addr_d = SDR_ADDR_W'(word_addr);
                            sdr_data_d = {ioctl_dout, lo_q};
                        end
                    end
                    S_CFG0: begin
                        cfg_hi_d = ioctl_dout[0];
                    end
                    S_CFG1: begin
                        board_cfg_d = {cfg_hi_q, ioctl_dout};
                    end
                    default: begin
                        region_d = region_q;
                    end
                endcase
            end
        end
    end

    assign ioctl_wait = sdr_req_q;
    assign sdr_req    = sdr_req_q;
    assign sdr_addr   = sdr_addr_q;
    assign sdr_data   = sdr_data_q;
    assign bram_wr    = bram_wr_q;
    assign bram_cs    = bram_cs_q;
    assign bram_addr  = bram_addr_q;
    assign bram_data  = bram_data_q;
    assign board_cfg  = board_cfg_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_rom_region_loader.sv
// tb_rom_region_loader: scoreboard bench for rom_region_loader.
// Expected SDRAM/BRAM writes are queued as bytes are driven.

module tb_rom_region_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        sdr_req;
    logic        sdr_ack;
    logic [24:0] sdr_addr;
    logic [15:0] sdr_data;
    logic        bram_wr;
    logic [4:0]  bram_cs;
    logic [24:0] bram_addr;
    logic [7:0]  bram_data;
    logic [8:0]  board_cfg;
    logic        load_done;
    logic        load_error;

    always #5 clk = ~clk;

    rom_region_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .sdr_req        (sdr_req),
        .sdr_ack        (sdr_ack),
        .sdr_addr       (sdr_addr),
        .sdr_data       (sdr_data),
        .bram_wr        (bram_wr),
        .bram_cs        (bram_cs),
        .bram_addr      (bram_addr),
        .bram_data      (bram_data),
        .board_cfg      (board_cfg),
        .load_done      (load_done),
        .load_error     (load_error)
    );

    typedef struct {
        bit          is_bram;
        logic [24:0] addr;
        logic [15:0] data;
        logic [4:0]  cs;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] bq[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         ack_delay = 1;
    int         last_hi = 0;
    int         last_wait = 0;

    logic [24:0] m_base [8] = '{25'h0000000, 25'h0200000, 25'h0400000,
                                25'h0800000, 25'h0, 25'h0, 25'h0, 25'h0};
    bit          m_reo  [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    logic [4:0]  m_cs   [8] = '{5'h00, 5'h00, 5'h00, 5'h00,
                                5'h01, 5'h02, 5'h04, 5'h08};

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {35'd0, ioctl_wait, sdr_req, sdr_addr, sdr_data, bram_wr,
                bram_cs, bram_addr, bram_data, board_cfg, load_done,
                load_error};
    endfunction

    task automatic push_ev(input bit b, input logic [24:0] a,
                           input logic [15:0] d, input logic [4:0] cs);
        ev_t e;
        e.is_bram = b;
        e.addr    = a;
        e.data    = d;
        e.cs      = cs;
        exp_q.push_back(e);
    endtask

    // Reference placement model for the bytes in bq.
    task automatic push_model(input int idx);
        int n = bq.size();
        if (m_cs[idx] != 5'd0) begin
            for (int i = 0; i < n; i++)
                push_ev(1, 25'(i), {8'h00, bq[i]}, m_cs[idx]);
        end else begin
            for (int k = 0; k < (n + 1) / 2; k++) begin
                int          e;
                logic [7:0]  hi;
                logic [31:0] a;
                e = k;
                if (m_reo[idx])
                    e = (k & ~3) | ((k & 1) << 1) | ((k >> 1) & 1);
                hi = (2 * k + 1 < n) ? bq[2 * k + 1] : 8'h00;
                a  = (32'(m_base[idx]) + 32'(e) * 2) & 32'h01FF_FFFF;
                push_ev(0, a[24:0], {hi, bq[2 * k]}, 5'd0);
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        while (ioctl_wait && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (ioctl_wait) check("wait_timeout", 1, 0);
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_region(input logic [7:0] idx);
        logic [31:0] s = 32'(bq.size());
        send(idx);
        send(s[31:24]);
        send(s[23:16]);
        send(s[15:8]);
        send(s[7:0]);
        foreach (bq[i]) send(bq[i]);
    endtask

    task automatic drain();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((exp_q.size() != 0 || sdr_req) && t < 500);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic new_dl();
        ioctl_download = 1'b0;
        @(negedge clk);
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    // SDRAM acknowledge: ack lands in the ack_delay-th cycle of sdr_req.
    initial begin
        int acnt = 0;
        sdr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (sdr_req && !sdr_ack && reset_n) begin
                acnt++;
                if (acnt >= ack_delay) begin
                    sdr_ack = 1'b1;
                    acnt    = 0;
                end
            end else begin
                sdr_ack = 1'b0;
                if (!sdr_req) acnt = 0;
            end
        end
    end

    // Output monitor: pops the scoreboard on each write.
    initial begin
        bit          req_prev = 0;
        bit          wait_prev = 0;
        int          hi_cnt = 0;
        int          w_cnt = 0;
        logic [24:0] hold_a = '0;
        logic [15:0] hold_d = '0;
        ev_t         e;
        forever begin
            @(negedge clk);
            if (sdr_req && !req_prev) begin
                hi_cnt = 1;
                hold_a = sdr_addr;
                hold_d = sdr_data;
                if (exp_q.size() == 0) begin
                    check("sdr_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sdr_kind", 0, e.is_bram);
                    check("sdr_addr", sdr_addr, e.addr);
                    check("sdr_data", sdr_data, e.data);
                end
            end else if (sdr_req) begin
                hi_cnt++;
                check("sdr_hold", {sdr_addr, sdr_data}, {hold_a, hold_d});
            end
            if (!sdr_req && req_prev) last_hi = hi_cnt;
            if (ioctl_wait && !wait_prev) w_cnt = 1;
            else if (ioctl_wait) w_cnt++;
            if (!ioctl_wait && wait_prev) last_wait = w_cnt;
            if (bram_wr) begin
                if (exp_q.size() == 0) begin
                    check("bram_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("bram_kind", 1, e.is_bram);
                    check("bram_cs", bram_cs, e.cs);
                    check("bram_addr", bram_addr, e.addr);
                    check("bram_data", bram_data, e.data[7:0]);
                end
            end
            req_prev  = sdr_req;
            wait_prev = ioctl_wait;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_dout     = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 0);
        reset_n = 1'b1;
        @(negedge clk);
        new_dl();

        // Region 0, four bytes, then terminator.
        push_ev(0, 25'h0000000, 16'h2211, 0);
        push_ev(0, 25'h0000002, 16'h4433, 0);
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_region(8'h00);
        drain();
        send(8'hFF);
        check("done_a", {load_done, load_error}, 2'b10);

        // Reordered sprite region, crypt BRAM region, odd-sized region.
        new_dl();
        check("done_cleared", load_done, 0);
        push_ev(0, 25'h0400000, 16'h0100, 0);
        push_ev(0, 25'h0400004, 16'h0302, 0);
        push_ev(0, 25'h0400002, 16'h0504, 0);
        push_ev(0, 25'h0400006, 16'h0706, 0);
        bq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        send_region(8'h02);
        drain();
        push_ev(1, 25'd0, 16'h00AA, 5'b00001);
        push_ev(1, 25'd1, 16'h00BB, 5'b00001);
        push_ev(1, 25'd2, 16'h00CC, 5'b00001);
        bq = '{8'hAA, 8'hBB, 8'hCC};
        send_region(8'h04);
        drain();
        push_ev(0, 25'h0000000, 16'h005A, 0);
        bq = '{8'h5A};
        send_region(8'h00);
        drain();
        bq = {};
        for (int i = 0; i < 11; i++) bq.push_back(8'($urandom));
        push_model(3);
        send_region(8'h03);
        drain();
        bq = {};
        for (int i = 0; i < 5; i++) bq.push_back(8'($urandom));
        push_model(6);
        send_region(8'h06);
        drain();
        bq = {};
        send_region(8'h01);
        send(8'hFF);
        check("done_b", {load_done, load_error}, 2'b10);

        // Slow acknowledge and config record.
        new_dl();
        ack_delay = 10;
        push_ev(0, 25'h0200000, 16'h3412, 0);
        bq = '{8'h12, 8'h34};
        send_region(8'h01);
        drain();
        check("req_len", last_hi, 10);
        check("wait_len", last_wait, 10);
        ack_delay = 1;
        send(8'hFE);
        send(8'h01);
        send(8'h2F);
        check("board_cfg", board_cfg, 9'h12F);
        send(8'hFF);
        check("done_c", {load_done, load_error}, 2'b10);

        // Bad tag, ignored bytes, recovery on a new download.
        new_dl();
        send(8'h09);
        check("bad_tag_err", load_error, 1);
        bq = '{8'h11, 8'h22};
        send_region(8'h00);
        send(8'hFF);
        check("err_sticky", {load_done, load_error}, 2'b01);
        new_dl();
        check("err_cleared", load_error, 0);
        check("cfg_retained", board_cfg, 9'h12F);

        // Download dropped in the middle of a region.
        push_ev(0, 25'h0000000, 16'h3CC3, 0);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        send(8'h04);
        send(8'hC3);
        send(8'h3C);
        drain();
        ioctl_download = 1'b0;
        @(negedge clk);
        check("drop_err", load_error, 1);

        // Reset while a request is outstanding.
        new_dl();
        ack_delay = 50;
        push_ev(0, 25'h0000000, 16'h7766, 0);
        bq = '{8'h66, 8'h77};
        send_region(8'h00);
        @(negedge clk);
        check("req_pending", sdr_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_async", outs(), 0);
        ioctl_download = 1'b0;
        ack_delay      = 1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_release", outs(), 0);
        new_dl();
        bq = {};
        for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
        push_model(0);
        send_region(8'h00);
        drain();
        send(8'hFF);
        check("done_d", {load_done, load_error}, 2'b10);
        check("cfg_after_reset", board_cfg, 9'h000);

        repeat (3) @(negedge clk);
        check("leftover", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
